sb_mixer_lo_ctrl: RTL and testbench

Digital local-oscillator sequencer for the single-balanced analog mixer. It derives the mixer's LO square wave from the system clock with a programmable divisor and drives the mixer LO input pin. It supports continuous and counted-burst operation, and applies configuration changes glitch-free. Configuration arrives over a 3-wire serial port on dedicated digital inputs; status is returned on dedicated outputs.

---
 rtl/sb_mixer_lo_pkg.sv | 33 +++
 rtl/sb_mixer_lo_cfg_rx.sv | 85 ++++++++
 rtl/sb_mixer_lo_ctrl.sv | 143 ++++++++++++++
 tb/tb_sb_mixer_lo_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_mixer_lo_pkg.sv
// Shared types and frame layout for the single-balanced mixer LO sequencer.
package sb_mixer_lo_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeCont  = 2'b01,
        ModeBurst = 2'b10,
        ModeRsvd  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {StOff, StRun, StBurst, StDone} state_e;

    localparam int unsigned MODE_W      = 2;
    localparam int unsigned DEF_DIV_W   = 10;
    localparam int unsigned DEF_BURST_W = 12;
    localparam int unsigned FRAME_W     = MODE_W + DEF_DIV_W + DEF_BURST_W;
    localparam int unsigned BURST_LSB   = 0;
    localparam int unsigned BIT_CNT_W   = 5;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 5'd31;

    function automatic int unsigned frame_w(input int unsigned div_w, input int unsigned burst_w);
        return MODE_W + div_w + burst_w;
    endfunction

    function automatic int unsigned div_lsb(input int unsigned burst_w);
        return BURST_LSB + burst_w;
    endfunction

    function automatic int unsigned mode_lsb(input int unsigned div_w, input int unsigned burst_w);
        return BURST_LSB + burst_w + div_w;
    endfunction

endpackage

// File: rtl/sb_mixer_lo_cfg_rx.sv
// 3-wire serial config receiver: synchronizes the async pins, shifts in a frame and
// presents a staged word with a one-cycle valid pulse, or flags a wrong-length frame.
module sb_mixer_lo_cfg_rx
    import sb_mixer_lo_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 csn_i,
    input  logic                 sclk_i,
    input  logic                 sdata_i,
    output logic [FRAME_LEN-1:0] frame_o,
    output logic                 frame_valid_o,
    output logic                 cfg_err_o
);

    // [1:0] are the synchronizer, [2] holds the previous synchronized value
    logic [2:0]           csn_q, csn_d, sclk_q, sclk_d;
    logic [1:0]           sdata_q, sdata_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d, stage_q, stage_d;
    logic [BIT_CNT_W-1:0] bcnt_q, bcnt_d;
    logic                 valid_q, valid_d, err_q, err_d;
    logic                 csn_rise, csn_fall, sclk_rise;

    assign csn_rise  = csn_q[1] & ~csn_q[2];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];

    always_comb begin
        csn_d   = {csn_q[1:0], csn_i};
        sclk_d  = {sclk_q[1:0], sclk_i};
        sdata_d = {sdata_q[0], sdata_i};
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        stage_d = stage_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (csn_fall) begin
            bcnt_d = '0;
        end else if (sclk_rise && !csn_q[1]) begin
            shift_d = {shift_q[FRAME_LEN-2:0], sdata_q[1]};
            if (bcnt_q != BIT_CNT_MAX) begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        if (csn_rise) begin
            if (bcnt_q == BIT_CNT_W'(FRAME_LEN)) begin
                stage_d = shift_q;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // csn idles high; resetting its sync chain high avoids a phantom rising edge
            csn_q   <= 3'b111;
            sclk_q  <= '0;
            sdata_q <= '0;
            shift_q <= '0;
            stage_q <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            shift_q <= shift_d;
            stage_q <= stage_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign frame_o       = stage_q;
    assign frame_valid_o = valid_q;
    assign cfg_err_o     = err_q;

endmodule

// File: rtl/sb_mixer_lo_ctrl.sv
// Mixer LO sequencer: programmable-divisor square wave with continuous and counted-burst
// modes; new configurations land only on period boundaries so every phase is full length.
module sb_mixer_lo_ctrl
    import sb_mixer_lo_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_csn,
    input  logic cfg_sclk,
    input  logic cfg_sdata,
    output logic lo_out,
    output logic busy,
    output logic done,
    output logic cfg_err
);

    localparam int unsigned FrameW  = frame_w(DIV_W, BURST_W);
    localparam int unsigned DivLsb  = div_lsb(BURST_W);
    localparam int unsigned ModeLsb = mode_lsb(DIV_W, BURST_W);

    logic [FrameW-1:0]  frame, pend_word_q, pend_word_d, cfg_word;
    logic               frame_valid, pend_q, pend_d, cfg_avail, apply, phase_end;
    state_e             state_q, state_d;
    logic               lo_q, lo_d, busy_q, busy_d, done_q, done_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d, cfg_div;
    logic [BURST_W-1:0] bcnt_q, bcnt_d, len_q, len_d, cfg_len, bcnt_inc;
    mode_e              cfg_mode;

    sb_mixer_lo_cfg_rx #(
        .FRAME_LEN(FrameW)
    ) u_cfg_rx (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .csn_i        (cfg_csn),
        .sclk_i       (cfg_sclk),
        .sdata_i      (cfg_sdata),
        .frame_o      (frame),
        .frame_valid_o(frame_valid),
        .cfg_err_o    (cfg_err)
    );

    // A frame arriving this cycle is newer than any pending one and may be applied directly
    assign cfg_avail = frame_valid | pend_q;
    assign cfg_word  = frame_valid ? frame : pend_word_q;
    assign cfg_mode  = mode_e'(cfg_word[ModeLsb +: MODE_W]);
    assign cfg_div   = cfg_word[DivLsb +: DIV_W];
    assign cfg_len   = cfg_word[BURST_LSB +: BURST_W];
    assign phase_end = (cnt_q == div_q);
    assign bcnt_inc  = bcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StOff;
            lo_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            div_q       <= '0;
            len_q       <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            div_q       <= div_d;
            len_q       <= len_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        div_d       = div_q;
        len_d       = len_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        // While toggling, the period boundary is the last cycle of a low phase
        unique case (state_q)
            StOff, StDone:  apply = cfg_avail;
            StRun, StBurst: apply = cfg_avail & phase_end & ~lo_q;
            default:        apply = 1'b0;
        endcase
        if (apply) begin
            div_d  = cfg_div;
            len_d  = cfg_len;
            cnt_d  = '0;
            bcnt_d = '0;
            pend_d = 1'b0;
            unique case (cfg_mode)
                ModeCont: begin
                    state_d = StRun;
                    lo_d    = 1'b1;
                end
                ModeBurst: begin
                    state_d = (cfg_len == '0) ? StDone : StBurst;
                    lo_d    = (cfg_len != '0);
                end
                default: begin
                    state_d = StOff;
                    lo_d    = 1'b0;
                end
            endcase
        end else if (state_q == StRun || state_q == StBurst) begin
            if (phase_end) begin
                cnt_d = '0;
                lo_d  = ~lo_q;
                if (state_q == StBurst && lo_q) begin
                    bcnt_d = bcnt_inc;
                    if (bcnt_inc == len_q) begin
                        state_d = StDone;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (frame_valid && !apply) begin
            pend_d      = 1'b1;
            pend_word_d = frame;
        end
        busy_d = (state_d == StRun) || (state_d == StBurst);
        done_d = (state_d == StDone);
    end

    always_comb begin
        lo_out = lo_q;
        busy   = busy_q;
        done   = done_q;
    end

endmodule

// File: tb/tb_sb_mixer_lo_ctrl.sv
// Self-checking bench for sb_mixer_lo_ctrl: a phase monitor compares measured LO phases
// against an expected-phase queue, plus table vectors and hand-written corner sequences.
module tb_sb_mixer_lo_ctrl;
    import sb_mixer_lo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_csn = 1'b1;
    logic cfg_sclk = 1'b0;
    logic cfg_sdata = 1'b0;
    logic lo_out, busy, done, cfg_err;

    sb_mixer_lo_ctrl #(
        .DIV_W  (10),
        .BURST_W(12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_csn  (cfg_csn),
        .cfg_sclk (cfg_sclk),
        .cfg_sdata(cfg_sdata),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit any_lvl;
        bit lvl;
        int len;
    } phase_t;

    typedef struct {
        logic [1:0] mode;
        int         div;
        int         len;
        logic       exp_busy;
        logic       exp_done;
        int         nph;
    } vec_t;

    phase_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     edges = 0;
    bit     skip = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Phase monitor: measures each completed LO phase, pops the expected one and compares
    initial begin
        int     run;
        logic   prev_lo;
        phase_t e;
        run = 0;
        prev_lo = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (lo_out !== prev_lo) begin
                edges++;
                if (skip) begin
                    skip = 0;
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (!e.any_lvl) check("phase_level", {31'd0, prev_lo}, {31'd0, e.lvl});
                    check("phase_len", run, e.len);
                end
                prev_lo = lo_out;
                run = 1;
            end else begin
                run++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [1:0] m, input int d, input int l);
        logic [31:0] w;
        w = '0;
        w[FRAME_W-1 -: 2] = m;
        w[21:12] = d[9:0];
        w[11:0]  = l[11:0];
        return w;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lowers csn and clocks in n bits MSB first; csn is left low
    task automatic send_bits(input int n, input logic [31:0] w);
        cfg_csn = 1'b0;
        cycles(4);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_sdata = w[i];
            cycles(4);
            cfg_sclk = 1'b1;
            cycles(4);
            cfg_sclk = 1'b0;
        end
        cycles(4);
    endtask

    task automatic send_frame(input int n, input logic [31:0] w);
        send_bits(n, w);
        cfg_csn = 1'b1;
        cycles(6);
    endtask

    task automatic push_phases(input int n, input int len);
        phase_t p;
        for (int i = 0; i < n; i++) begin
            p.any_lvl = 1;
            p.lvl = 0;
            p.len = len;
            exp_q.push_back(p);
        end
    endtask

    task automatic push_lvl(input bit lvl, input int len);
        phase_t p;
        p.any_lvl = 0;
        p.lvl = lvl;
        p.len = len;
        exp_q.push_back(p);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycles(1);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        skip = 0;
    endtask

    task automatic wait_rise(input int budget);
        logic last;
        bit   seen;
        last = lo_out;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (lo_out === 1'b1 && last === 1'b0) seen = 1;
            last = lo_out;
        end
        check("lo_rise_seen", {31'd0, seen}, 32'd1);
    endtask

    vec_t vecs[7];
    int   e0;

    initial begin
        vecs[0] = '{2'b01, 3, 0, 1'b1, 1'b0, 200};
        vecs[1] = '{2'b01, 0, 0, 1'b1, 1'b0, 20};
        vecs[2] = '{2'b01, 1, 0, 1'b1, 1'b0, 20};
        vecs[3] = '{2'b01, 7, 0, 1'b1, 1'b0, 8};
        vecs[4] = '{2'b00, 5, 9, 1'b0, 1'b0, 0};
        vecs[5] = '{2'b11, 2, 4, 1'b0, 1'b0, 0};
        vecs[6] = '{2'b01, 3, 0, 1'b1, 1'b0, 8};

        cycles(3);
        check("rst_lo_out", {31'd0, lo_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst_n = 1'b1;
        cycles(5);

        foreach (vecs[k]) begin
            send_frame(FRAME_W, mk(vecs[k].mode, vecs[k].div, vecs[k].len));
            cycles(40);
            check($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].exp_busy});
            check($sformatf("vec%0d_done", k), {31'd0, done}, {31'd0, vecs[k].exp_done});
            check($sformatf("vec%0d_cfg_err", k), {31'd0, cfg_err}, 32'd0);
            if (vecs[k].nph > 0) begin
                skip = 1;
                push_phases(vecs[k].nph, vecs[k].div + 1);
                drain($sformatf("vec%0d_phases", k), vecs[k].nph * (vecs[k].div + 1) + 40);
            end else begin
                e0 = edges;
                cycles(40);
                check($sformatf("vec%0d_no_edges", k), edges - e0, 0);
                check($sformatf("vec%0d_lo_low", k), {31'd0, lo_out}, 32'd0);
            end
        end

        // div 3 -> div 0 with csn released during a high phase
        send_bits(FRAME_W, mk(2'b01, 0, 0));
        wait_rise(40);
        skip = 1;
        push_lvl(0, 4);
        for (int i = 0; i < 6; i++) begin
            push_lvl(1, 1);
            push_lvl(0, 1);
        end
        cfg_csn = 1'b1;
        drain("switch_no_runt", 80);

        // Counted burst from OFF
        send_frame(FRAME_W, mk(2'b00, 0, 0));
        cycles(20);
        send_bits(FRAME_W, mk(2'b10, 1, 5));
        skip = 1;
        for (int i = 0; i < 4; i++) begin
            push_lvl(1, 2);
            push_lvl(0, 2);
        end
        push_lvl(1, 2);
        e0 = edges;
        cfg_csn = 1'b1;
        cycles(8);
        check("burst_busy", {31'd0, busy}, 32'd1);
        drain("burst_phases", 60);
        cycles(30);
        check("burst_edges", edges - e0, 10);
        check("burst_end_busy", {31'd0, busy}, 32'd0);
        check("burst_end_done", {31'd0, done}, 32'd1);
        check("burst_end_lo", {31'd0, lo_out}, 32'd0);

        // Wrong-length frames must not disturb a running LO
        send_frame(FRAME_W, mk(2'b01, 2, 0));
        cycles(40);
        check("cont2_done_clr", {31'd0, done}, 32'd0);
        send_frame(23, mk(2'b01, 0, 0));
        check("short_cfg_err", {31'd0, cfg_err}, 32'd1);
        check("short_busy", {31'd0, busy}, 32'd1);
        send_frame(25, mk(2'b00, 0, 0));
        check("long_cfg_err", {31'd0, cfg_err}, 32'd1);
        skip = 1;
        push_phases(6, 3);
        drain("bad_frame_lo_kept", 60);
        send_frame(FRAME_W, mk(2'b00, 0, 0));
        cycles(20);
        check("good_clr_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("off_busy", {31'd0, busy}, 32'd0);
        check("off_lo", {31'd0, lo_out}, 32'd0);

        // Zero-length burst: straight to DONE without a pulse
        e0 = edges;
        send_frame(FRAME_W, mk(2'b10, 1, 0));
        cycles(20);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_no_pulse", edges - e0, 0);
        send_frame(FRAME_W, mk(2'b00, 0, 0));
        cycles(10);
        check("off_clr_done", {31'd0, done}, 32'd0);

        // Reset during a burst high phase
        send_bits(FRAME_W, mk(2'b10, 3, 100));
        cfg_csn = 1'b1;
        wait_rise(40);
        cycles(1);
        rst_n = 1'b0;
        cycles(1);
        check("rst_mid_lo", {31'd0, lo_out}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        e0 = edges;
        cycles(60);
        check("post_rst_edges", edges - e0, 0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_cfg_err", {31'd0, cfg_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
